// File: rtl/bfis_host_if_if.sv
// Host/engine-facing signal bundle for bfis_host_if.
// The slave modport is the front end's view; master is the host/engine side.
interface bfis_host_if_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DIM        = 4
);
  logic [DATA_WIDTH-1:0]     data_in;
  logic                      data_in_valid;
  logic                      data_in_ready;
  logic [DIM*DATA_WIDTH-1:0] query_out;
  logic [15:0]               k_out;
  logic [DATA_WIDTH-1:0]     vertex_id_out;
  logic                      start_out;
  logic [DATA_WIDTH-1:0]     result_in;
  logic                      result_valid_in;
  logic                      done_in;
  logic [DATA_WIDTH-1:0]     data_out;
  logic                      data_out_valid;
  logic                      data_out_ready;
  logic                      busy_out;
  logic                      err_out;

  modport slave (
    input  data_in, data_in_valid, result_in, result_valid_in, done_in, data_out_ready,
    output data_in_ready, query_out, k_out, vertex_id_out, start_out,
           data_out, data_out_valid, busy_out, err_out
  );

  modport master (
    output data_in, data_in_valid, result_in, result_valid_in, done_in, data_out_ready,
    input  data_in_ready, query_out, k_out, vertex_id_out, start_out,
           data_out, data_out_valid, busy_out, err_out
  );
endinterface

// File: rtl/bfis_host_if.sv
// Host stream front end for the bfis engine: frame decode, launch, result buffering, drain.
// Define BFIS_HOST_CYCLE_CNT_EN to append the search cycle count as the final drained word.
module bfis_host_if #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DIM        = 4,
  parameter int                    K_MAX      = 8,
  parameter logic [DATA_WIDTH-1:0] SYNC_WORD  = 32'hFFFF_FFFF,
  parameter int                    CYC_WIDTH  = 32
) (
  input  logic          clk_in,
  input  logic          rst_in,
  bfis_host_if_if.slave bus
);
  localparam int IDX_W = $clog2(DIM + 2);
  localparam int PTR_W = (K_MAX > 1) ? $clog2(K_MAX) : 1;
  localparam int CNT_W = $clog2(K_MAX + 1);
  localparam logic [15:0]      K_MAX_W  = 16'(K_MAX);
  localparam logic [IDX_W-1:0] IDX_K    = IDX_W'(DIM);
  localparam logic [IDX_W-1:0] IDX_VID  = IDX_W'(DIM + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(K_MAX - 1);

  typedef enum logic [2:0] {IDLE, COLLECT, LAUNCH, RUN, DRAIN} state_t;

  state_t                state_reg, state_next;
  logic [IDX_W-1:0]      idx_reg;
  logic [15:0]           k_reg;
  logic [DATA_WIDTH-1:0] vid_reg;
  logic                  err_reg;
  logic [DATA_WIDTH-1:0] buf_mem [K_MAX];
  logic [PTR_W-1:0]      wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]      cap_reg, sent_reg;
  logic [DATA_WIDTH-1:0] out_data_reg;
  logic                  out_valid_reg;

  logic        ready;
  logic        accept;
  logic        is_sync;
  logic        payload;
  logic [15:0] k_word;
  logic        capture;
  logic        out_adv;
  logic        load_res;
  logic        load_any;

`ifdef BFIS_HOST_CYCLE_CNT_EN
  logic [CYC_WIDTH-1:0] cyc_reg;
  logic                 cyc_sent_reg;
  logic                 load_cyc;
`endif

  assign ready   = (state_reg == IDLE) || (state_reg == COLLECT);
  assign accept  = bus.data_in_valid && ready;
  assign is_sync = (bus.data_in == SYNC_WORD);
  assign payload = (state_reg == COLLECT) && accept && !is_sync;
  assign k_word  = bus.data_in[15:0];
  // captured can never exceed k_out, so the buffer cannot overflow
  assign capture = (state_reg == RUN) && bus.result_valid_in && (16'(cap_reg) < k_reg);
  assign out_adv = !out_valid_reg || bus.data_out_ready;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    load_res   = 1'b0;
    load_any   = 1'b0;
`ifdef BFIS_HOST_CYCLE_CNT_EN
    load_cyc   = 1'b0;
`endif
    case (state_reg)
      IDLE:    if (accept && is_sync) state_next = COLLECT;
      COLLECT: begin
        if (payload) begin
          if (idx_reg == IDX_K && k_word == 16'd0) state_next = IDLE;
          else if (idx_reg == IDX_VID)             state_next = LAUNCH;
        end
      end
      LAUNCH:  state_next = RUN;
      RUN:     if (bus.done_in) state_next = DRAIN;
      DRAIN: begin
        if (out_adv) begin
          if (sent_reg != cap_reg) begin
            load_res = 1'b1;
            load_any = 1'b1;
          end
`ifdef BFIS_HOST_CYCLE_CNT_EN
          else if (!cyc_sent_reg) begin
            load_cyc = 1'b1;
            load_any = 1'b1;
          end
`endif
          else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Query elements are registered straight into the engine-facing output.
  for (genvar gi = 0; gi < DIM; gi++) begin : g_query
    logic [DATA_WIDTH-1:0] elem_reg;
    always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in)                                      elem_reg <= '0;
      else if (payload && idx_reg == IDX_W'(gi))       elem_reg <= bus.data_in;
    end
    assign bus.query_out[gi*DATA_WIDTH +: DATA_WIDTH] = elem_reg;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      idx_reg       <= '0;
      k_reg         <= '0;
      vid_reg       <= '0;
      err_reg       <= 1'b0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      cap_reg       <= '0;
      sent_reg      <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      if (state_reg == IDLE && accept && is_sync) begin
        idx_reg <= '0;
        err_reg <= 1'b0;
      end
      if (state_reg == COLLECT && accept && is_sync) idx_reg <= '0;
      if (payload) begin
        idx_reg <= idx_reg + 1'b1;
        if (idx_reg == IDX_K) begin
          if (k_word == 16'd0) begin
            err_reg <= 1'b1;
          end else if (k_word > K_MAX_W) begin
            k_reg   <= K_MAX_W;
            err_reg <= 1'b1;
          end else begin
            k_reg   <= k_word;
          end
        end
        if (idx_reg == IDX_VID) vid_reg <= bus.data_in;
      end
      if (state_reg == LAUNCH) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        cap_reg    <= '0;
        sent_reg   <= '0;
      end
      if (capture) begin
        cap_reg    <= cap_reg + 1'b1;
        wr_ptr_reg <= (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + 1'b1;
      end
      if (load_res) begin
        out_data_reg <= buf_mem[rd_ptr_reg];
        rd_ptr_reg   <= (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + 1'b1;
        sent_reg     <= sent_reg + 1'b1;
      end
`ifdef BFIS_HOST_CYCLE_CNT_EN
      if (load_cyc) out_data_reg <= DATA_WIDTH'(cyc_reg);
`endif
      // Output register only moves when empty or being taken, so it holds under backpressure.
      if (out_adv) out_valid_reg <= load_any;
    end
  end

  always_ff @(posedge clk_in) begin
    if (capture) buf_mem[wr_ptr_reg] <= bus.result_in;
  end

`ifdef BFIS_HOST_CYCLE_CNT_EN
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cyc_reg      <= '0;
      cyc_sent_reg <= 1'b0;
    end else begin
      if (state_reg == LAUNCH) begin
        cyc_reg      <= '0;
        cyc_sent_reg <= 1'b0;
      end else if (state_reg == RUN && cyc_reg != '1) begin
        cyc_reg <= cyc_reg + 1'b1;
      end
      if (load_cyc) cyc_sent_reg <= 1'b1;
    end
  end
`endif

  assign bus.data_in_ready  = ready;
  assign bus.k_out          = k_reg;
  assign bus.vertex_id_out  = vid_reg;
  assign bus.start_out      = (state_reg == LAUNCH);
  assign bus.data_out       = out_data_reg;
  assign bus.data_out_valid = out_valid_reg;
  assign bus.busy_out       = (state_reg != IDLE);
  assign bus.err_out        = err_reg;
endmodule

// File: tb/tb_bfis_host_if.sv
// Directed bench for bfis_host_if: framing, k clamping, backpressure, resync and reset abort.
module tb_bfis_host_if;
  localparam int DW = 32;
  localparam int DIM = 4;
  localparam int KM = 8;
  localparam logic [DW-1:0] SYNC = 32'hFFFF_FFFF;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  int tests = 0;
  int fails = 0;
  logic [DW-1:0] got [$];
  logic [DW-1:0] exp_q [$];

  bfis_host_if_if #(.DATA_WIDTH(DW), .DIM(DIM)) bus ();

  bfis_host_if #(
    .DATA_WIDTH(DW), .DIM(DIM), .K_MAX(KM), .SYNC_WORD(SYNC), .CYC_WIDTH(32)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .bus(bus)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_word(input logic [DW-1:0] w);
    bus.data_in = w;
    bus.data_in_valid = 1'b1;
    @(posedge clk_in); #1;
    bus.data_in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [DW-1:0] q0, q1, q2, q3, k, vid);
    send_word(SYNC);
    send_word(q0); send_word(q1); send_word(q2); send_word(q3);
    send_word(k);
    send_word(vid);
  endtask

  // Called in the LAUNCH cycle; returns in the first DRAIN cycle.
  task automatic run_engine(input int n, input logic [DW-1:0] base, input int done_cyc);
    @(posedge clk_in); #1;
    check("start_one_cycle", bus.start_out, 1'b0);
    check("ready_low_run", bus.data_in_ready, 1'b0);
    for (int i = 1; i <= done_cyc; i++) begin
      bus.result_valid_in = (i <= n);
      bus.result_in = base + DW'(i - 1);
      bus.done_in = (i == done_cyc);
      @(posedge clk_in); #1;
    end
    bus.result_valid_in = 1'b0;
    bus.done_in = 1'b0;
  endtask

  task automatic collect(input bit toggle, input string tag);
    logic prev_hold;
    logic [DW-1:0] prev_data;
    prev_hold = 1'b0;
    prev_data = '0;
    got.delete();
    for (int cyc = 0; cyc < 200; cyc++) begin
      bus.data_out_ready = toggle ? (cyc % 2 == 1) : 1'b1;
      if (prev_hold) begin
        check({tag, "_hold_valid"}, bus.data_out_valid, 1'b1);
        check({tag, "_hold_data"}, bus.data_out, prev_data);
      end
      if (bus.data_out_valid && bus.data_out_ready) begin
        got.push_back(bus.data_out);
        $display("[TB] %s out word %0d = %08h", tag, got.size() - 1, bus.data_out);
      end
      prev_hold = bus.data_out_valid && !bus.data_out_ready;
      prev_data = bus.data_out;
      if (!bus.busy_out && !bus.data_out_valid) break;
      @(posedge clk_in); #1;
    end
    bus.data_out_ready = 1'b0;
    check({tag, "_back_idle"}, bus.busy_out, 1'b0);
    check({tag, "_word_count"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got.size()) check({tag, "_word"}, got[i], exp_q[i]);
    end
  endtask

  initial begin
    bus.data_in = '0;
    bus.data_in_valid = 1'b0;
    bus.result_in = '0;
    bus.result_valid_in = 1'b0;
    bus.done_in = 1'b0;
    bus.data_out_ready = 1'b0;

    // Reset state
    #12;
    check("rst_busy", bus.busy_out, 1'b0);
    check("rst_start", bus.start_out, 1'b0);
    check("rst_query", bus.query_out, 128'd0);
    check("rst_k", bus.k_out, 16'd0);
    check("rst_valid", bus.data_out_valid, 1'b0);
    check("rst_err", bus.err_out, 1'b0);
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    check("idle_ready", bus.data_in_ready, 1'b1);
    $display("[TB] reset released");

    // Basic frame, k=4
    send_frame(32'd5, 32'd7, 32'd1, 32'd1, 32'd4, 32'd1);
    $display("[TB] frame 1 sent");
    check("t1_start", bus.start_out, 1'b1);
    check("t1_query", bus.query_out, 128'h00000001_00000001_00000007_00000005);
    check("t1_k", bus.k_out, 16'd4);
    check("t1_vid", bus.vertex_id_out, 32'd1);
    check("t1_ready_launch", bus.data_in_ready, 1'b0);
    run_engine(4, 32'hA000_0000, 10);
    check("t1_drain_busy", bus.busy_out, 1'b1);
    check("t1_first_latency", bus.data_out_valid, 1'b0);
    exp_q = '{32'hA000_0000, 32'hA000_0001, 32'hA000_0002, 32'hA000_0003};
`ifdef BFIS_HOST_CYCLE_CNT_EN
    exp_q.push_back(32'd10);
`endif
    collect(1'b0, "t1");

    // Extra results dropped, backpressure toggled
    send_frame(32'd10, 32'd20, 32'd30, 32'd40, 32'd4, 32'd2);
    $display("[TB] frame 2 sent");
    check("t2_start", bus.start_out, 1'b1);
    run_engine(6, 32'hB000_0000, 8);
    exp_q = '{32'hB000_0000, 32'hB000_0001, 32'hB000_0002, 32'hB000_0003};
`ifdef BFIS_HOST_CYCLE_CNT_EN
    exp_q.push_back(32'd8);
`endif
    collect(1'b1, "t2");

    // k=0 aborts the frame
    send_word(SYNC);
    send_word(32'd1); send_word(32'd2); send_word(32'd3); send_word(32'd4);
    send_word(32'd0);
    $display("[TB] frame 3 (k=0) sent");
    check("t3_err", bus.err_out, 1'b1);
    check("t3_busy", bus.busy_out, 1'b0);
    check("t3_no_start", bus.start_out, 1'b0);
    send_word(32'd6);
    check("t3_vid_dropped_busy", bus.busy_out, 1'b0);
    check("t3_vid_no_start", bus.start_out, 1'b0);

    // k=20 clamps to K_MAX
    send_word(SYNC);
    check("t4_err_cleared", bus.err_out, 1'b0);
    send_word(32'd1); send_word(32'd2); send_word(32'd3); send_word(32'd4);
    send_word(32'd20);
    check("t4_err", bus.err_out, 1'b1);
    check("t4_k_clamp", bus.k_out, 16'd8);
    send_word(32'd3);
    $display("[TB] frame 4 (k=20) sent");
    check("t4_start", bus.start_out, 1'b1);
    run_engine(10, 32'hC000_0000, 12);
    exp_q = '{32'hC000_0000, 32'hC000_0001, 32'hC000_0002, 32'hC000_0003,
              32'hC000_0004, 32'hC000_0005, 32'hC000_0006, 32'hC000_0007};
`ifdef BFIS_HOST_CYCLE_CNT_EN
    exp_q.push_back(32'd12);
`endif
    collect(1'b0, "t4");

    // Resync mid-frame
    send_word(SYNC); send_word(32'd1); send_word(32'd2);
    send_word(SYNC);
    send_word(32'd11); send_word(32'd12); send_word(32'd13); send_word(32'd14);
    send_word(32'd2); send_word(32'd5);
    $display("[TB] frame 5 (resync) sent");
    check("t5_start", bus.start_out, 1'b1);
    check("t5_query", bus.query_out, 128'h0000000E_0000000D_0000000C_0000000B);
    check("t5_k", bus.k_out, 16'd2);
    check("t5_vid", bus.vertex_id_out, 32'd5);
    check("t5_err", bus.err_out, 1'b0);
    run_engine(2, 32'hE000_0000, 3);
    exp_q = '{32'hE000_0000, 32'hE000_0001};
`ifdef BFIS_HOST_CYCLE_CNT_EN
    exp_q.push_back(32'd3);
`endif
    collect(1'b0, "t5");

    // Reset during RUN
    send_frame(32'd1, 32'd2, 32'd3, 32'd4, 32'd3, 32'd7);
    @(posedge clk_in); #1;
    bus.result_valid_in = 1'b1;
    bus.result_in = 32'h1234_5678;
    @(posedge clk_in); #1;
    rst_in = 1'b1;
    #1;
    $display("[TB] reset asserted mid-RUN");
    check("t6_busy", bus.busy_out, 1'b0);
    check("t6_query", bus.query_out, 128'd0);
    check("t6_k", bus.k_out, 16'd0);
    check("t6_vid", bus.vertex_id_out, 32'd0);
    bus.result_valid_in = 1'b0;
    @(posedge clk_in); #1;
    rst_in = 1'b0;

    // Reset during DRAIN with a word waiting
    send_frame(32'd1, 32'd2, 32'd3, 32'd4, 32'd2, 32'd7);
    run_engine(2, 32'hF000_0000, 3);
    @(posedge clk_in); #1;
    check("t6_drain_valid", bus.data_out_valid, 1'b1);
    check("t6_drain_data", bus.data_out, 32'hF000_0000);
    rst_in = 1'b1;
    #1;
    $display("[TB] reset asserted mid-DRAIN");
    check("t6_drain_rst_valid", bus.data_out_valid, 1'b0);
    check("t6_drain_rst_data", bus.data_out, 32'd0);
    check("t6_drain_rst_busy", bus.busy_out, 1'b0);
    @(posedge clk_in); #1;
    rst_in = 1'b0;

    // Normal frame after reset abort
    send_frame(32'd2, 32'd3, 32'd4, 32'd5, 32'd3, 32'd9);
    $display("[TB] frame 7 sent");
    check("t7_start", bus.start_out, 1'b1);
    check("t7_query", bus.query_out, 128'h00000005_00000004_00000003_00000002);
    check("t7_vid", bus.vertex_id_out, 32'd9);
    run_engine(3, 32'hD000_0000, 5);
    exp_q = '{32'hD000_0000, 32'hD000_0001, 32'hD000_0002};
`ifdef BFIS_HOST_CYCLE_CNT_EN
    exp_q.push_back(32'd5);
`endif
    collect(1'b0, "t7");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
